// File: rtl/bulls_cows_pkg.sv
// Shared types and display helpers for the two-player Bulls & Cows core.
package bulls_cows_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCORE_W = 3;
    localparam int unsigned DSP_W   = 6;
    localparam int unsigned NUM_DSP = 8;

    typedef enum logic [3:0] {
        ST_SET1,
        ST_SET2,
        ST_GUESS1,
        ST_SHOW1,
        ST_GUESS2,
        ST_SHOW2,
        ST_ERR,
        ST_WIN,
        ST_DRAW
    } state_t;

    // Display code: {en, hex[3:0], dp}
    typedef logic [DSP_W-1:0] dsp_t;

    localparam dsp_t DSP_BLANK = 6'b0_0000_0;
    localparam dsp_t DSP_E     = 6'b1_1110_1;
    localparam dsp_t DSP_D     = 6'b1_1101_0;

    function automatic dsp_t dsp(input logic [3:0] hex, input logic dp);
        return {1'b1, hex, dp};
    endfunction

endpackage

// File: rtl/bc_scorer.sv
// Combinational bulls/cows scoring of a guess against a secret, plus
// digit-distinctness check of the guess.
module bc_scorer
    import bulls_cows_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] i_guess,
    input  logic [4*NUM_DIGITS-1:0] i_secret,
    output logic [SCORE_W-1:0]      o_bulls_c,
    output logic [SCORE_W-1:0]      o_cows_c,
    output logic                    o_valid_c
);

    always_comb begin
        o_bulls_c = '0;
        o_cows_c  = '0;
        o_valid_c = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            for (int j = 0; j < int'(NUM_DIGITS); j++) begin
                if (i == j) begin
                    if (i_guess[4*i +: 4] == i_secret[4*i +: 4])
                        o_bulls_c = o_bulls_c + SCORE_W'(1);
                end else begin
                    if (i_guess[4*i +: 4] == i_secret[4*j +: 4])
                        o_cows_c = o_cows_c + SCORE_W'(1);
                    if ((j > i) && (i_guess[4*i +: 4] == i_guess[4*j +: 4]))
                        o_valid_c = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bulls_cows_game.sv
// Two-player Bulls & Cows game core: secret entry, alternating scored guesses,
// attempt limit with draw, and registered 8-digit display codes.
module bulls_cows_game
    import bulls_cows_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned MAX_ATTEMPTS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] guess,
    input  logic                    confirm,
    output logic [5:0]              d1,
    output logic [5:0]              d2,
    output logic [5:0]              d3,
    output logic [5:0]              d4,
    output logic [5:0]              d5,
    output logic [5:0]              d6,
    output logic [5:0]              d7,
    output logic [5:0]              d8,
    output logic [1:0]              winner,
    output logic                    game_over
);

    localparam int unsigned GW = 4 * NUM_DIGITS;

    state_t               r_state;
    state_t               w_next_state;
    state_t               r_ret;
    logic                 r_confirm_q;
    logic                 w_ev;
    logic [GW-1:0]        r_secret1;
    logic [GW-1:0]        r_secret2;
    logic [CNT_W-1:0]     r_att1;
    logic [CNT_W-1:0]     r_att2;
    logic [SCORE_W-1:0]   r_bulls;
    logic [SCORE_W-1:0]   r_cows;
    logic [1:0]           r_winner;
    logic                 r_game_over;
    dsp_t                 r_d [NUM_DSP];
    dsp_t                 w_d [NUM_DSP];

    logic [GW-1:0]        w_target;
    logic [GW-1:0]        w_win_secret;
    logic [SCORE_W-1:0]   w_bulls;
    logic [SCORE_W-1:0]   w_cows;
    logic                 w_valid;
    logic                 w_p2;
    logic [CNT_W-1:0]     w_att;
    logic                 w_solved;

    assign w_ev     = confirm & ~r_confirm_q;
    assign w_target = (r_state == ST_GUESS2) ? r_secret1 : r_secret2;
    assign w_solved = (r_bulls == SCORE_W'(NUM_DIGITS));

    bc_scorer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_scorer (
        .i_guess   (guess),
        .i_secret  (w_target),
        .o_bulls_c (w_bulls),
        .o_cows_c  (w_cows),
        .o_valid_c (w_valid)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_SET1;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (w_ev) begin
            case (r_state)
                ST_SET1:   w_next_state = w_valid ? ST_SET2   : ST_ERR;
                ST_SET2:   w_next_state = w_valid ? ST_GUESS1 : ST_ERR;
                ST_GUESS1: w_next_state = w_valid ? ST_SHOW1  : ST_ERR;
                ST_SHOW1:  w_next_state = w_solved ? ST_WIN : ST_GUESS2;
                ST_GUESS2: w_next_state = w_valid ? ST_SHOW2  : ST_ERR;
                ST_SHOW2: begin
                    if (w_solved)                            w_next_state = ST_WIN;
                    else if (r_att2 == CNT_W'(MAX_ATTEMPTS)) w_next_state = ST_DRAW;
                    else                                     w_next_state = ST_GUESS1;
                end
                ST_ERR:    w_next_state = r_ret;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // Secrets, attempt counters, latched score and result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_confirm_q <= 1'b1;
            r_secret1   <= '0;
            r_secret2   <= '0;
            r_att1      <= '0;
            r_att2      <= '0;
            r_bulls     <= '0;
            r_cows      <= '0;
            r_ret       <= ST_SET1;
            r_winner    <= 2'd0;
            r_game_over <= 1'b0;
        end else begin
            r_confirm_q <= confirm;
            if (w_ev && !w_valid &&
                (r_state == ST_SET1 || r_state == ST_SET2 ||
                 r_state == ST_GUESS1 || r_state == ST_GUESS2))
                r_ret <= r_state;
            if (w_ev && w_valid) begin
                case (r_state)
                    ST_SET1: r_secret1 <= guess;
                    ST_SET2: r_secret2 <= guess;
                    ST_GUESS1: begin
                        r_bulls <= w_bulls;
                        r_cows  <= w_cows;
                        if (r_att1 < CNT_W'(MAX_ATTEMPTS)) r_att1 <= r_att1 + CNT_W'(1);
                    end
                    ST_GUESS2: begin
                        r_bulls <= w_bulls;
                        r_cows  <= w_cows;
                        if (r_att2 < CNT_W'(MAX_ATTEMPTS)) r_att2 <= r_att2 + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            if (r_state != ST_WIN && w_next_state == ST_WIN) begin
                r_winner    <= (r_state == ST_SHOW1) ? 2'd1 : 2'd2;
                r_game_over <= 1'b1;
            end else if (r_state != ST_DRAW && w_next_state == ST_DRAW) begin
                r_winner    <= 2'd3;
                r_game_over <= 1'b1;
            end
        end
    end

    assign w_p2 = (r_state == ST_SET2) || (r_state == ST_GUESS2) || (r_state == ST_SHOW2);
    assign w_att = w_p2 ? r_att2 : r_att1;
    // The player who won found the other player's secret
    assign w_win_secret = (r_winner == 2'd1) ? r_secret2 : r_secret1;

    // Screen contents for the current state
    always_comb begin
        for (int i = 0; i < int'(NUM_DSP); i++) w_d[i] = DSP_BLANK;
        case (r_state)
            ST_SET1, ST_SET2, ST_GUESS1, ST_GUESS2: begin
                w_d[7] = dsp({3'b000, w_p2} + 4'd1,
                             (r_state == ST_SET1) || (r_state == ST_SET2));
                w_d[6] = dsp(w_att[7:4], 1'b0);
                w_d[5] = dsp(w_att[3:0], 1'b0);
                for (int i = 0; i < int'(NUM_DIGITS); i++)
                    w_d[i] = dsp(guess[4*i +: 4], 1'b0);
            end
            ST_SHOW1, ST_SHOW2: begin
                w_d[7] = dsp({3'b000, w_p2} + 4'd1, 1'b0);
                w_d[6] = dsp(w_att[7:4], 1'b0);
                w_d[5] = dsp(w_att[3:0], 1'b0);
                w_d[3] = dsp({1'b0, r_bulls}, 1'b0);
                w_d[1] = dsp({1'b0, r_cows}, 1'b0);
            end
            ST_ERR: begin
                for (int i = 0; i < int'(NUM_DSP); i++) w_d[i] = DSP_E;
            end
            ST_WIN: begin
                w_d[7] = dsp({2'b00, r_winner}, 1'b1);
                for (int i = 0; i < int'(NUM_DIGITS); i++)
                    w_d[i] = dsp(w_win_secret[4*i +: 4], 1'b1);
            end
            ST_DRAW: begin
                for (int i = 0; i < int'(NUM_DSP); i++) w_d[i] = DSP_D;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_DSP); i++) begin
            if (reset) r_d[i] <= DSP_BLANK;
            else       r_d[i] <= w_d[i];
        end
    end

    assign d1        = r_d[0];
    assign d2        = r_d[1];
    assign d3        = r_d[2];
    assign d4        = r_d[3];
    assign d5        = r_d[4];
    assign d6        = r_d[5];
    assign d7        = r_d[6];
    assign d8        = r_d[7];
    assign winner    = r_winner;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_bulls_cows_game.sv
// Bench for bulls_cows_game: two instances (4 digits / 3 attempts and
// 2 digits / 2 attempts) checked every cycle against a game-level model.
module tb_bulls_cows_game;

    localparam int M_SET   = 0;
    localparam int M_GUESS = 1;
    localparam int M_SHOW  = 2;
    localparam int M_ERR   = 3;
    localparam int M_WON   = 4;
    localparam int M_DRAWN = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        confirm = 1'b1;
    logic [15:0] g0 = '0;
    logic [7:0]  g1 = '0;

    logic [5:0] a1, a2, a3, a4, a5, a6, a7, a8;
    logic [5:0] b1, b2, b3, b4, b5, b6, b7, b8;
    logic [1:0] win0, win1;
    logic       go0, go1;

    always #5 clock = ~clock;

    bulls_cows_game #(.NUM_DIGITS(4), .MAX_ATTEMPTS(3)) u_dut0 (
        .clock(clock), .reset(reset), .guess(g0), .confirm(confirm),
        .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7), .d8(a8),
        .winner(win0), .game_over(go0)
    );

    bulls_cows_game #(.NUM_DIGITS(2), .MAX_ATTEMPTS(2)) u_dut1 (
        .clock(clock), .reset(reset), .guess(g1), .confirm(confirm),
        .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7), .d8(b8),
        .winner(win1), .game_over(go1)
    );

    wire [47:0] v0 = {a8, a7, a6, a5, a4, a3, a2, a1};
    wire [47:0] v1 = {b8, b7, b6, b5, b4, b3, b2, b1};

    // Game model per instance: mode + active player, secrets indexed by owner
    int nd [2] = '{4, 2};
    int ma [2] = '{3, 2};
    int mode [2];
    int player [2];
    int ret_mode [2];
    int sec [2][3];
    int att [2][3];
    int m_bulls [2];
    int m_cows [2];
    int m_win [2];
    bit prev_conf [2];
    logic [47:0] exp_disp [2];

    int errors = 0;
    int checks = 0;

    function automatic int digit(int v, int i);
        return (v >> (4 * i)) & 15;
    endfunction

    function automatic bit is_valid(int v, int n);
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (digit(v, i) == digit(v, j)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_bulls(int g, int s, int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (digit(g, i) == digit(s, i)) c++;
        return c;
    endfunction

    function automatic int count_cows(int g, int s, int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (i != j && digit(g, i) == digit(s, j)) c++;
        return c;
    endfunction

    function automatic logic [5:0] code(int hex, bit dp);
        return {1'b1, 4'(hex), dp};
    endfunction

    function automatic logic [47:0] screen(int k, int g);
        logic [5:0] d [8];
        logic [47:0] r;
        int p = player[k];
        for (int i = 0; i < 8; i++) d[i] = 6'b0;
        case (mode[k])
            M_SET, M_GUESS: begin
                d[7] = code(p, mode[k] == M_SET);
                d[6] = code(att[k][p] >> 4, 1'b0);
                d[5] = code(att[k][p] & 15, 1'b0);
                for (int i = 0; i < nd[k]; i++) d[i] = code(digit(g, i), 1'b0);
            end
            M_SHOW: begin
                d[7] = code(p, 1'b0);
                d[6] = code(att[k][p] >> 4, 1'b0);
                d[5] = code(att[k][p] & 15, 1'b0);
                d[3] = code(m_bulls[k], 1'b0);
                d[1] = code(m_cows[k], 1'b0);
            end
            M_ERR:   for (int i = 0; i < 8; i++) d[i] = code(14, 1'b1);
            M_WON: begin
                d[7] = code(m_win[k], 1'b1);
                for (int i = 0; i < nd[k]; i++) d[i] = code(digit(sec[k][3 - m_win[k]], i), 1'b1);
            end
            M_DRAWN: for (int i = 0; i < 8; i++) d[i] = code(13, 1'b0);
            default: ;
        endcase
        for (int i = 0; i < 8; i++) r[6*i +: 6] = d[i];
        return r;
    endfunction

    task automatic model_edge(int k, int g);
        bit ev;
        int p;
        if (reset) begin
            mode[k] = M_SET; player[k] = 1; ret_mode[k] = M_SET;
            for (int i = 0; i < 3; i++) begin sec[k][i] = 0; att[k][i] = 0; end
            m_bulls[k] = 0; m_cows[k] = 0; m_win[k] = 0;
            prev_conf[k] = 1'b1;
            exp_disp[k] = '0;
            return;
        end
        exp_disp[k] = screen(k, g);
        ev = confirm && !prev_conf[k];
        prev_conf[k] = confirm;
        if (!ev) return;
        p = player[k];
        case (mode[k])
            M_SET: begin
                if (!is_valid(g, nd[k])) begin ret_mode[k] = M_SET; mode[k] = M_ERR; end
                else begin
                    sec[k][p] = g;
                    if (p == 1) player[k] = 2;
                    else begin player[k] = 1; mode[k] = M_GUESS; end
                end
            end
            M_GUESS: begin
                if (!is_valid(g, nd[k])) begin ret_mode[k] = M_GUESS; mode[k] = M_ERR; end
                else begin
                    m_bulls[k] = count_bulls(g, sec[k][3 - p], nd[k]);
                    m_cows[k]  = count_cows(g, sec[k][3 - p], nd[k]);
                    if (att[k][p] < ma[k]) att[k][p]++;
                    mode[k] = M_SHOW;
                end
            end
            M_SHOW: begin
                if (m_bulls[k] == nd[k]) begin mode[k] = M_WON; m_win[k] = p; end
                else if (p == 1) begin player[k] = 2; mode[k] = M_GUESS; end
                else if (att[k][2] == ma[k]) begin mode[k] = M_DRAWN; m_win[k] = 3; end
                else begin player[k] = 1; mode[k] = M_GUESS; end
            end
            M_ERR: mode[k] = ret_mode[k];
            default: ;
        endcase
    endtask

    task automatic check(string name, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("disp0", v0, exp_disp[0]);
        check("disp1", v1, exp_disp[1]);
        check("winner0", 48'(win0), 48'(m_win[0]));
        check("winner1", 48'(win1), 48'(m_win[1]));
        check("over0", 48'(go0), 48'(mode[0] == M_WON || mode[0] == M_DRAWN));
        check("over1", 48'(go1), 48'(mode[1] == M_WON || mode[1] == M_DRAWN));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0, int'(g0));
        model_edge(1, int'(g1));
        @(negedge clock);
        compare_all();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(int a, int b);
        g0 = 16'(a); g1 = 8'(b);
        steps(2);
        confirm = 1'b1;
        steps(2);
        confirm = 1'b0;
        steps(2);
    endtask

    task automatic do_reset();
        reset = 1'b1; steps(2); reset = 1'b0; steps(1);
    endtask

    function automatic int rand_guess(int k);
        int r = $urandom_range(0, 9);
        int mask = (1 << (4 * nd[k])) - 1;
        int v = 0;
        if (r < 2) return $urandom & mask;
        if (r < 5 && mode[k] == M_GUESS) return sec[k][3 - player[k]];
        for (int t = 0; t < 30; t++) begin
            v = $urandom & mask;
            if (is_valid(v, nd[k])) break;
        end
        return v;
    endfunction

    initial begin
        // Pin the model's scoring rules with hand-computed values
        check("pin_bulls4", 48'(count_bulls('h5687, 'h5678, 4)), 48'd2);
        check("pin_cows4",  48'(count_cows('h5687, 'h5678, 4)), 48'd2);
        check("pin_cows2",  48'(count_cows('h21, 'h12, 2)), 48'd2);
        check("pin_valid",  48'(is_valid('h1123, 4)), 48'd0);

        // Confirm held through reset is not an event
        reset = 1'b1; confirm = 1'b1;
        steps(3);
        reset = 1'b0;
        steps(3);
        confirm = 1'b0;
        steps(2);
        check("set1_d8", 48'(a8), 48'(6'b1_0001_1));

        press('h1123, 'h11);
        check("err_d1", 48'(a1), 48'(6'b1_1110_1));
        press('h1234, 'h34);
        check("err_ret_d8", 48'(a8), 48'(6'b1_0001_1));
        press('h1234, 'h34);
        press('h5678, 'h12);
        check("nd2_d4_blank", 48'(b4), 48'd0);
        check("nd2_d3_blank", 48'(b3), 48'd0);

        press('h5687, 'h21);
        check("show1_bulls", 48'(a4), 48'(6'b1_0010_0));
        check("show1_cows",  48'(a2), 48'(6'b1_0010_0));
        check("show1_att",   48'({a7, a6}), 48'({6'b1_0000_0, 6'b1_0001_0}));
        check("nd2_bulls",   48'(b4), 48'(6'b1_0000_0));
        check("nd2_cows",    48'(b2), 48'(6'b1_0010_0));

        press(0, 0);
        press('h1234, 'h34);
        press('h1234, 'h34);
        check("win_winner", 48'(win0), 48'd2);
        check("win_over",   48'(go0), 48'd1);
        check("win_d1",     48'(a1), 48'(6'b1_0100_1));
        press('h5678, 'h12);
        check("win_hold",   48'(win0), 48'd2);

        // Draw: no correct guesses until attempt limit
        do_reset();
        press('h1234, 'h34);
        press('h5678, 'h12);
        for (int r = 0; r < 3; r++) begin
            for (int q = 0; q < 4; q++) press('h9ABC, 'h9A);
        end
        check("draw_w0", 48'(win0), 48'd3);
        check("draw_w1", 48'(win1), 48'd3);
        check("draw_d1", 48'(a1), 48'(6'b1_1101_0));

        // Reset while in GUESS2
        do_reset();
        press('h1234, 'h34);
        press('h5678, 'h12);
        press('h9ABC, 'h9A);
        press('h9ABC, 'h9A);
        reset = 1'b1;
        step();
        check("rst_blank", v0, 48'd0);
        reset = 1'b0;
        steps(2);
        check("rst_set1", 48'(a8), 48'(6'b1_0001_1));

        // Held confirm gives exactly one transition
        g0 = 16'h1234; g1 = 8'h34;
        confirm = 1'b1;
        steps(50);
        confirm = 1'b0;
        steps(2);
        check("held_set2", 48'(a8), 48'(6'b1_0010_1));

        // Randomised play
        for (int c = 0; c < 6000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) confirm = ~confirm;
            if ($urandom_range(0, 5) == 0) begin
                g0 = 16'(rand_guess(0));
                g1 = 8'(rand_guess(1));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
